// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit and its datapath.
// Holds the FSM state set, opcodes, select encodings and the per-state Moore control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_EXECLUI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // mem_wait marks states whose ir_write/pc_update must be qualified by mem_ready.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       mem_wait;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1; c.mem_wait = 1'b1; c.ir_write = 1'b1; c.pc_update = 1'b1;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT;
      end
      S_DECODE:  begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEMADR:  begin c.alu_src_a = SRCA_RD1;   c.alu_src_b = SRCB_IMM; end
      S_MEMREAD: begin c.mem_req = 1'b1; c.mem_wait = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:   begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_MEMWR: begin
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.mem_wait = 1'b1; c.adr_src = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT;
      end
      S_EXECLUI: begin c.alu_src_a = SRCA_ZERO; c.alu_src_b = SRCB_IMM; end
      S_ALUWB:   begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_SUB;
        c.result_src = RES_ALUOUT; c.branch = 1'b1;
      end
      // PC takes the target computed in DECODE while the ALU forms OldPC+4 for rd.
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
        c.result_src = RES_ALUOUT; c.pc_update = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps ALUOp plus instruction function bits to alu_control.
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unsupported funct3 values fall back to add rather than trapping.
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control unit: Moore FSM with registered control word,
// immediate-type decoder and ALU decoder, stalling on the memory ready handshake.
module mc_controller
  import mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal
);

  state_t state, nxt;
  ctrl_t  ctrl;
  logic   pc_update;

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BEQ:       nxt = S_BEQ;
          OP_JAL:       nxt = S_JAL;
          OP_LUI:       nxt = S_EXECLUI;
          default:      nxt = S_TRAP;
        endcase
      end
      S_MEMADR:  nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR, S_EXECI, S_EXECLUI, S_JAL: nxt = S_ALUWB;
      S_ALUWB, S_BEQ: nxt = S_FETCH;
      S_TRAP:    nxt = S_TRAP;
      default:   nxt = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so outputs leave flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      ctrl    <= state_ctrl(RESET_STATE);
      illegal <= 1'b0;
    end else begin
      state   <= nxt;
      ctrl    <= state_ctrl(nxt);
      illegal <= illegal | (nxt == S_TRAP);
    end
  end

  assign pc_update  = ctrl.pc_update & (mem_ready | ~ctrl.mem_wait);
  assign mem_req    = ctrl.mem_req & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign ir_write   = ctrl.ir_write & (mem_ready | ~ctrl.mem_wait) & ~reset;
  assign pc_write   = (pc_update | (ctrl.branch & zero)) & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      OP_LUI:  imm_src = IMM_U;
      default: imm_src = IMM_I;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level trace model, vector table,
// randomized instruction stream and hand-written reset/trap corner cases.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal)
  );

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111,
                         LUI = 7'b0110111, BAD = 7'b0001111;

  typedef struct packed {
    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac, is;
  } obs_t;

  typedef struct { logic mr; logic z; obs_t o; } cyc_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z;
    int fs; int ms; int exp_cyc; logic [2:0] exp_ac; logic [2:0] exp_is;
  } vec_t;

  cyc_t q[$];
  int checks = 0, errors = 0;
  logic [2:0] last_ac, dec_is;

  function automatic logic [2:0] imm_of(logic [6:0] o);
    if (o == SW) return 3'b001;
    if (o == BEQ) return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI) return 3'b100;
    return 3'b000;
  endfunction

  // Arithmetic meaning of funct3: only a register-register op with bit 30 set subtracts.
  function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (o == RT && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(logic mr, logic z, obs_t o);
    cyc_t c;
    c.mr = mr; c.z = z; c.o = o;
    q.push_back(c);
  endfunction

  function automatic obs_t blank(logic [2:0] is);
    obs_t o;
    o = '0; o.is = is;
    return o;
  endfunction

  // Expected per-cycle trace of one instruction, given fetch and data-memory stall counts.
  function automatic void build(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int fs, int ms);
    obs_t c, fe, mw, ex;
    logic [2:0] im;
    im = imm_of(o);
    q.delete();
    fe = blank(im); fe.mem_req = 1; fe.sb = 2'b10; fe.rs = 2'b10;
    for (int i = 0; i < fs; i++) push(1'b0, rbit(), fe);
    c = fe; c.ir_write = 1; c.pc_write = 1; push(1'b1, rbit(), c);
    c = blank(im); c.sa = 2'b01; c.sb = 2'b01; push(rbit(), rbit(), c);
    ex = blank(im); ex.reg_write = 1;
    if (o == LW || o == SW) begin
      c = blank(im); c.sa = 2'b10; c.sb = 2'b01; push(rbit(), rbit(), c);
      mw = blank(im); mw.mem_req = 1; mw.adr_src = 1; mw.mem_write = (o == SW);
      for (int i = 0; i < ms; i++) push(1'b0, rbit(), mw);
      push(1'b1, rbit(), mw);
      if (o == LW) begin c = ex; c.rs = 2'b01; push(rbit(), rbit(), c); end
    end else if (o == RT || o == IT || o == LUI) begin
      c = blank(im); c.sb = (o == RT) ? 2'b00 : 2'b01;
      c.sa = (o == LUI) ? 2'b11 : 2'b10;
      c.ac = (o == LUI) ? 3'b000 : alu_of(o, f3, f7);
      push(rbit(), rbit(), c);
      push(rbit(), rbit(), ex);
    end else if (o == BEQ) begin
      c = blank(im); c.sa = 2'b10; c.ac = 3'b001; c.pc_write = z; push(rbit(), z, c);
    end else if (o == JAL) begin
      c = blank(im); c.sa = 2'b01; c.sb = 2'b10; c.pc_write = 1; push(rbit(), rbit(), c);
      push(rbit(), rbit(), ex);
    end
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.mem_req = mem_req; a.mem_write = mem_write; a.adr_src = adr_src;
    a.ir_write = ir_write; a.pc_write = pc_write; a.reg_write = reg_write;
    a.illegal = illegal; a.rs = result_src; a.sa = alu_src_a; a.sb = alu_src_b;
    a.ac = alu_control; a.is = imm_src;
    return a;
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic apply(cyc_t c, string name, int idx);
    obs_t a;
    @(negedge clk);
    mem_ready = c.mr; zero = c.z;
    #1;
    a = sample();
    if (a.sa == 2'b10) last_ac = a.ac;
    check(name, idx, 32'(a), 32'(c.o));
  endtask

  // Fetch signature after the instruction: DUT must be back in FETCH (probe holds mem_ready low).
  task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int fs, int ms,
                           string name, output int ncyc);
    op = o; funct3 = f3; funct7b5 = f7;
    build(o, f3, f7, z, fs, ms);
    last_ac = 3'b000;
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i], name, i);
      if (i == fs + 1) dec_is = imm_src;
    end
    ncyc = q.size();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check({name, "_ret"}, 0, {mem_req, adr_src, ir_write, pc_write, alu_src_b},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
  endtask

  vec_t tbl[14];
  logic [6:0] ops[7];

  initial begin
    int n;
    obs_t tr;
    reset = 1'b1; op = RT; funct3 = 0; funct7b5 = 0; zero = 0; mem_ready = 1'b1;
    ops = '{LW, SW, RT, IT, BEQ, JAL, LUI};
    tbl[0]  = '{RT,  3'd0, 1'b0, 1'b0, 0, 0, 4, 3'b000, 3'b000};
    tbl[1]  = '{RT,  3'd0, 1'b1, 1'b0, 0, 0, 4, 3'b001, 3'b000};
    tbl[2]  = '{RT,  3'd2, 1'b0, 1'b0, 0, 0, 4, 3'b101, 3'b000};
    tbl[3]  = '{RT,  3'd6, 1'b0, 1'b0, 0, 0, 4, 3'b011, 3'b000};
    tbl[4]  = '{RT,  3'd7, 1'b0, 1'b0, 0, 0, 4, 3'b010, 3'b000};
    tbl[5]  = '{IT,  3'd0, 1'b1, 1'b0, 0, 0, 4, 3'b000, 3'b000};
    tbl[6]  = '{IT,  3'd6, 1'b0, 1'b0, 0, 0, 4, 3'b011, 3'b000};
    tbl[7]  = '{IT,  3'd1, 1'b0, 1'b0, 0, 0, 4, 3'b000, 3'b000};
    tbl[8]  = '{LW,  3'd2, 1'b0, 1'b0, 0, 3, 8, 3'b000, 3'b000};
    tbl[9]  = '{SW,  3'd2, 1'b0, 1'b0, 2, 1, 7, 3'b000, 3'b001};
    tbl[10] = '{BEQ, 3'd0, 1'b0, 1'b1, 0, 0, 3, 3'b001, 3'b010};
    tbl[11] = '{BEQ, 3'd0, 1'b0, 1'b0, 0, 0, 3, 3'b001, 3'b010};
    tbl[12] = '{JAL, 3'd0, 1'b0, 1'b0, 0, 0, 4, 3'b000, 3'b011};
    tbl[13] = '{LUI, 3'd0, 1'b0, 1'b0, 1, 0, 5, 3'b000, 3'b100};

    // Reset: strobes forced low even with mem_ready high.
    repeat (2) @(negedge clk);
    #1;
    check("reset_strobes", 0, {mem_req, mem_write, ir_write, pc_write, reg_write}, 5'b0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    tr = blank(3'b000); tr.mem_req = 1; tr.sb = 2'b10; tr.rs = 2'b10;
    check("reset_fetch", 0, 32'(sample()), 32'(tr));

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].fs, tbl[i].ms, "vec", n);
      check("vec_cycles", i, n, tbl[i].exp_cyc);
      check("vec_alu", i, last_ac, tbl[i].exp_ac);
      check("vec_imm", i, dec_is, tbl[i].exp_is);
    end

    for (int i = 0; i < 150; i++)
      run_instr(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), rbit(), rbit(),
                $urandom_range(0, 2), $urandom_range(0, 2), "rand", n);

    // Reset while stalled in MEMWR.
    op = SW; funct3 = 3'd2; funct7b5 = 0;
    build(SW, 3'd2, 1'b0, 1'b0, 0, 3);
    for (int i = 0; i < 4; i++) apply(q[i], "memwr", i);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    check("memwr_reset", 0, {mem_req, mem_write, pc_write, reg_write}, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tr = blank(3'b001); tr.mem_req = 1; tr.sb = 2'b10; tr.rs = 2'b10;
    check("memwr_fetch", 0, 32'(sample()), 32'(tr));

    // Unsupported opcode: TRAP with sticky illegal, then recovery by reset.
    op = BAD;
    build(BAD, 3'd0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) apply(q[i], "trap_pre", i);
    tr = blank(3'b000); tr.illegal = 1;
    for (int i = 0; i < 10; i++) begin
      cyc_t c;
      c.mr = rbit(); c.z = rbit(); c.o = tr;
      apply(c, "trap", i);
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check("trap_reset", 0, {mem_req, mem_write, ir_write, pc_write, reg_write}, 5'b0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    tr = blank(3'b000); tr.mem_req = 1; tr.sb = 2'b10; tr.rs = 2'b10;
    check("trap_cleared", 0, 32'(sample()), 32'(tr));
    run_instr(RT, 3'd0, 1'b1, 1'b0, 0, 0, "post_trap", n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
